// File: rtl/exc_sequencer.sv
// rtl/exc_sequencer.sv - interrupt/undefined-instruction entry sequencer
// Freezes the front end, drains the back end, saves EPC into $k0 and redirects PC to the handler.
module exc_sequencer #(
   parameter logic [31:0] IRQ_VECTOR   = 32'h8000_0004,
   parameter logic [31:0] EXC_VECTOR   = 32'h8000_0008,
   parameter int          DRAIN_CYCLES = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        irq,
   input  logic        ui,
   input  logic [31:0] id_pc_plus4,
   input  logic        branch_pending,
   input  logic        eret,
   input  logic        wb_reg_write,
   output logic        stall,
   output logic        flush,
   output logic        k0_we,
   output logic [31:0] k0_wdata,
   output logic        pc_redirect,
   output logic [31:0] redirect_target,
   output logic        in_kernel,
   output logic [1:0]  exc_cause
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DRAIN,
      S_SAVE,
      S_REDIRECT,
      S_KERNEL
   } state_t;

   localparam logic [1:0] CAUSE_NONE = 2'b00;
   localparam logic [1:0] CAUSE_IRQ  = 2'b01;
   localparam logic [1:0] CAUSE_UI   = 2'b10;
   localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);

   state_t      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [31:0] epc_q, epc_d;
   logic [1:0]  cause_q, cause_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 3'd0;
         epc_q   <= 32'd0;
         cause_q <= CAUSE_NONE;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         epc_q   <= epc_d;
         cause_q <= cause_d;
      end
   end

   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      epc_d           = epc_q;
      cause_d         = cause_q;
      stall           = 1'b0;
      flush           = 1'b0;
      k0_we           = 1'b0;
      k0_wdata        = 32'd0;
      pc_redirect     = 1'b0;
      redirect_target = 32'd0;
      in_kernel       = 1'b0;

      case (state_q)
         S_IDLE: begin
            // ui always wins; irq is only taken when no branch resolves in ID
            if (ui) begin
               cause_d = CAUSE_UI;
               epc_d   = id_pc_plus4;
               cnt_d   = DRAIN_LOAD;
               state_d = S_DRAIN;
            end else if (irq && !branch_pending) begin
               cause_d = CAUSE_IRQ;
               epc_d   = id_pc_plus4 - 32'd4;
               cnt_d   = DRAIN_LOAD;
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            stall = 1'b1;
            flush = (cnt_q == DRAIN_LOAD);
            if (cnt_q == 3'd0) begin
               state_d = S_SAVE;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         S_SAVE: begin
            stall = 1'b1;
            // the $k0 port must never collide with a WB write
            if (!wb_reg_write) begin
               k0_we    = 1'b1;
               k0_wdata = epc_q;
               state_d  = S_REDIRECT;
            end
         end
         S_REDIRECT: begin
            stall           = 1'b1;
            pc_redirect     = 1'b1;
            redirect_target = (cause_q == CAUSE_UI) ? EXC_VECTOR : IRQ_VECTOR;
            state_d         = S_KERNEL;
         end
         S_KERNEL: begin
            in_kernel = 1'b1;
            if (eret) begin
               cause_d = CAUSE_NONE;
               epc_d   = 32'd0;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign exc_cause = cause_q;

endmodule

// File: tb/tb_exc_sequencer.sv
// tb/tb_exc_sequencer.sv - self-checking bench for exc_sequencer
// Cycle model tracks age since acceptance; directed vectors add literal expectations.
module tb_exc_sequencer;

   localparam int D = 3;
   localparam logic [31:0] IRQ_V = 32'h8000_0004;
   localparam logic [31:0] EXC_V = 32'h8000_0008;

   logic        clk = 1'b0;
   logic        reset;
   logic        irq, ui, branch_pending, eret, wb_reg_write;
   logic [31:0] id_pc_plus4;
   logic        stall, flush, k0_we, pc_redirect, in_kernel;
   logic [31:0] k0_wdata, redirect_target;
   logic [1:0]  exc_cause;

   int checks   = 0;
   int failures = 0;

   exc_sequencer #(.IRQ_VECTOR(IRQ_V), .EXC_VECTOR(EXC_V), .DRAIN_CYCLES(D)) dut (
      .clk(clk), .reset(reset), .irq(irq), .ui(ui), .id_pc_plus4(id_pc_plus4),
      .branch_pending(branch_pending), .eret(eret), .wb_reg_write(wb_reg_write),
      .stall(stall), .flush(flush), .k0_we(k0_we), .k0_wdata(k0_wdata),
      .pc_redirect(pc_redirect), .redirect_target(redirect_target),
      .in_kernel(in_kernel), .exc_cause(exc_cause)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Model: busy counts cycles since acceptance; EPC saved once draining is over and WB is free
   bit          m_busy, m_saved, m_kernel;
   int          m_age;
   logic [1:0]  m_cause;
   logic [31:0] m_epc;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_busy <= 0; m_saved <= 0; m_kernel <= 0; m_age <= 0;
         m_cause <= 2'b00; m_epc <= 32'd0;
      end else if (m_kernel) begin
         if (eret) begin
            m_kernel <= 0; m_cause <= 2'b00; m_epc <= 32'd0;
         end
      end else if (m_busy) begin
         if (m_saved) begin
            m_busy <= 0; m_saved <= 0; m_kernel <= 1;
         end else if (m_age > D && !wb_reg_write) begin
            m_saved <= 1;
         end
         m_age <= m_age + 1;
      end else if (ui) begin
         m_busy <= 1; m_age <= 1; m_cause <= 2'b10; m_epc <= id_pc_plus4;
      end else if (irq && !branch_pending) begin
         m_busy <= 1; m_age <= 1; m_cause <= 2'b01; m_epc <= id_pc_plus4 - 32'd4;
      end
   end

   always @(negedge clk) begin : compare
      logic e_k0;
      e_k0 = m_busy && !m_saved && (m_age > D) && !wb_reg_write;
      chk("stall", 32'(stall), 32'(m_busy));
      chk("flush", 32'(flush), 32'(m_busy && m_age == 1));
      chk("k0_we", 32'(k0_we), 32'(e_k0));
      chk("k0_wdata", k0_wdata, e_k0 ? m_epc : 32'd0);
      chk("pc_redirect", 32'(pc_redirect), 32'(m_busy && m_saved));
      chk("redirect_target", redirect_target,
          (m_busy && m_saved) ? ((m_cause == 2'b10) ? EXC_V : IRQ_V) : 32'd0);
      chk("in_kernel", 32'(in_kernel), 32'(m_kernel));
      chk("exc_cause", 32'(exc_cause), 32'(m_cause));
      if (k0_we && wb_reg_write) chk("k0_wb_collision", 32'd1, 32'd0);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic do_eret();
      step();
      eret = 1'b1;
      step();
      eret = 1'b0;
      settle();
      chk("eret_in_kernel", 32'(in_kernel), 32'd0);
      chk("eret_cause", 32'(exc_cause), 32'd0);
   endtask

   initial begin
      reset = 1'b1; irq = 0; ui = 0; branch_pending = 0; eret = 0; wb_reg_write = 0;
      id_pc_plus4 = 32'd0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      step(); settle();
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_cause", 32'(exc_cause), 32'd0);
      chk("rst_kernel", 32'(in_kernel), 32'd0);

      // irq at T, nominal timing
      step(); irq = 1; id_pc_plus4 = 32'h40; settle();
      chk("t0_stall", 32'(stall), 32'd0);
      step(); irq = 0; settle();
      chk("t1_flush", 32'(flush), 32'd1);
      chk("t1_cause", 32'(exc_cause), 32'd1);
      step(); settle();
      chk("t2_flush", 32'(flush), 32'd0);
      step(); step(); settle();
      chk("t4_k0_we", 32'(k0_we), 32'd1);
      chk("t4_k0_wdata", k0_wdata, 32'h0000_003C);
      step(); settle();
      chk("t5_redirect", 32'(pc_redirect), 32'd1);
      chk("t5_target", redirect_target, 32'h8000_0004);
      step(); settle();
      chk("t6_kernel", 32'(in_kernel), 32'd1);
      chk("t6_stall", 32'(stall), 32'd0);
      do_eret();

      // ui
      step(); ui = 1; id_pc_plus4 = 32'h100;
      step(); ui = 0;
      repeat (D) step(); settle();
      chk("ui_k0_wdata", k0_wdata, 32'h0000_0100);
      step(); settle();
      chk("ui_target", redirect_target, 32'h8000_0008);
      chk("ui_cause", 32'(exc_cause), 32'd2);
      step(); do_eret();

      // irq+ui together, irq held through kernel, re-accepted after eret
      step(); irq = 1; ui = 1; id_pc_plus4 = 32'h200;
      step(); ui = 0; settle();
      chk("both_cause", 32'(exc_cause), 32'd2);
      repeat (D + 2) step();
      repeat (4) step(); settle();
      chk("masked_stall", 32'(stall), 32'd0);
      chk("masked_kernel", 32'(in_kernel), 32'd1);
      eret = 1; id_pc_plus4 = 32'h300;
      step(); eret = 0; settle();
      chk("reacc_idle", 32'(in_kernel), 32'd0);
      step(); irq = 0; settle();
      chk("reacc_flush", 32'(flush), 32'd1);
      chk("reacc_cause", 32'(exc_cause), 32'd1);
      repeat (D) step(); settle();
      chk("reacc_k0", k0_wdata, 32'h0000_02FC);
      repeat (2) step(); do_eret();

      // irq deferred by branch_pending
      step(); irq = 1; branch_pending = 1; id_pc_plus4 = 32'h500; settle();
      chk("bp0_stall", 32'(stall), 32'd0);
      step(); id_pc_plus4 = 32'h504; settle();
      chk("bp1_stall", 32'(stall), 32'd0);
      step(); branch_pending = 0; id_pc_plus4 = 32'h600; settle();
      chk("bp2_stall", 32'(stall), 32'd0);
      step(); irq = 0; settle();
      chk("bp_flush", 32'(flush), 32'd1);
      repeat (D) step(); settle();
      chk("bp_k0", k0_wdata, 32'h0000_05FC);
      repeat (2) step(); do_eret();

      // WB conflict delays the $k0 write by 3 cycles
      step(); ui = 1; id_pc_plus4 = 32'h700;
      step(); ui = 0;
      repeat (D) step(); wb_reg_write = 1; settle();
      chk("wb0_k0_we", 32'(k0_we), 32'd0);
      chk("wb0_stall", 32'(stall), 32'd1);
      step(); settle();
      chk("wb1_k0_we", 32'(k0_we), 32'd0);
      step(); settle();
      step(); wb_reg_write = 0; settle();
      chk("wb3_k0_we", 32'(k0_we), 32'd1);
      chk("wb3_k0_wdata", k0_wdata, 32'h0000_0700);
      step(); settle();
      chk("wb_redirect", 32'(pc_redirect), 32'd1);
      do_eret();

      // asynchronous reset while waiting in SAVE
      step(); ui = 1; id_pc_plus4 = 32'h800;
      step(); ui = 0;
      repeat (D) step(); wb_reg_write = 1; settle();
      chk("pre_rst_stall", 32'(stall), 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("arst_stall", 32'(stall), 32'd0);
      chk("arst_k0_we", 32'(k0_we), 32'd0);
      chk("arst_redirect", 32'(pc_redirect), 32'd0);
      chk("arst_cause", 32'(exc_cause), 32'd0);
      wb_reg_write = 0;
      step(); step(); reset = 1'b0;
      repeat (6) step(); settle();
      chk("post_rst_stall", 32'(stall), 32'd0);

      // epc wraps for id_pc_plus4 = 0
      step(); irq = 1; id_pc_plus4 = 32'h0;
      step(); irq = 0;
      repeat (D) step(); settle();
      chk("wrap_k0_we", 32'(k0_we), 32'd1);
      chk("wrap_k0_wdata", k0_wdata, 32'hFFFF_FFFC);
      repeat (2) step(); do_eret();

      step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1);
   end

endmodule
